// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch advanced by rising edges of a slow level signal.
// Start/stop/clear control; all outputs registered in the clk_in domain.
module bcd_stopwatch #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       tick_out,
    output logic       rollover
);

    localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t state;
    logic   s1, s2, s3;
    logic   edge_det;
    logic   advance;
    logic   at_limit;

    assign edge_det = s2 & ~s3;
    assign advance  = edge_det && (state == RUN) && !stop && !clear;
    assign at_limit = (min_tens == LIM_TENS) && (min_ones == LIM_ONES)
                   && (sec_tens == 4'd5) && (sec_ones == 4'd9);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            running  <= 1'b0;
            tick_out <= 1'b0;
            rollover <= 1'b0;
        end else begin
            s1       <= slow_clk;
            s2       <= s1;
            s3       <= s2;
            tick_out <= advance;
            rollover <= advance && at_limit;
            if (clear) begin
                state    <= IDLE;
                running  <= 1'b0;
                sec_ones <= 4'd0;
                sec_tens <= 4'd0;
                min_ones <= 4'd0;
                min_tens <= 4'd0;
            end else begin
                case (state)
                    IDLE, PAUSE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (edge_det) begin
                            // BCD ripple; wrap to 00:00 after MIN_LIMIT:59
                            if (at_limit) begin
                                sec_ones <= 4'd0;
                                sec_tens <= 4'd0;
                                min_ones <= 4'd0;
                                min_tens <= 4'd0;
                            end else if (sec_ones != 4'd9) begin
                                sec_ones <= sec_ones + 4'd1;
                            end else begin
                                sec_ones <= 4'd0;
                                if (sec_tens != 4'd5) begin
                                    sec_tens <= sec_tens + 4'd1;
                                end else begin
                                    sec_tens <= 4'd0;
                                    if (min_ones != 4'd9) begin
                                        min_ones <= min_ones + 4'd1;
                                    end else begin
                                        min_ones <= 4'd0;
                                        min_tens <= min_tens + 4'd1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: elapsed-seconds reference model,
// directed scenarios followed by a randomized control/slow_clk phase.
module tb_bcd_stopwatch;

    localparam int LIM   = 2;
    localparam int TOTAL = (LIM + 1) * 60;

    logic       clk_in   = 1'b0;
    logic       rst      = 1'b1;
    logic       slow_clk = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       clear    = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, tick_out, rollover;

    bcd_stopwatch #(.MIN_LIMIT(LIM)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .running  (running),
        .tick_out (tick_out),
        .rollover (rollover)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int passes   = 0;
    int tick_cnt = 0;
    int roll_cnt = 0;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m = s / 60;
        int x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    // Reference model: mode 0 idle, 1 run, 2 pause; elapsed time in seconds
    int          mode = 0;
    int          secs = 0;
    bit          exp_run = 1'b0;
    bit          prev_samp = 1'b0;
    bit          e_m;
    longint      cyc = 0;
    longint      due[$];
    logic [16:0] sb[$];

    always @(posedge clk_in) begin
        if (rst) begin
            mode = 0; secs = 0; exp_run = 1'b0; prev_samp = 1'b0; cyc = 0;
            due.delete();
            sb.delete();
        end else begin
            e_m = (due.size() > 0) && (due[0] == cyc);
            if (e_m) void'(due.pop_front());
            if (clear) begin
                mode = 0; secs = 0;
            end else if (mode == 1) begin
                if (stop) mode = 2;
                else if (e_m) begin
                    secs = secs + 1;
                    if (secs == TOTAL) secs = 0;
                    sb.push_back({secs == 0, to_bcd(secs)});
                end
            end else if (start) begin
                mode = 1;
            end
            exp_run = (mode == 1);
            // a rising edge sampled now is acted on two clocks later
            if (slow_clk && !prev_samp) due.push_back(cyc + 2);
            prev_samp = slow_clk;
            cyc = cyc + 1;
        end
    end

    logic [16:0] exp_e;
    always @(posedge clk_in) begin
        #1;
        chk("running", running, exp_run);
        if (tick_out) begin
            tick_cnt++;
            if (rollover) roll_cnt++;
            if (sb.size() == 0) chk("spurious_tick", tick_out, 0);
            else begin
                exp_e = sb.pop_front();
                chk("tick_digits", {min_tens, min_ones, sec_tens, sec_ones}, exp_e[15:0]);
                chk("tick_rollover", rollover, exp_e[16]);
            end
        end else begin
            chk("rollover_no_tick", rollover, 0);
            chk("missed_tick", sb.size(), 0);
            sb.delete();
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse(input logic [2:0] ctl);
        @(negedge clk_in);
        {clear, stop, start} = ctl;
        @(negedge clk_in);
        {clear, stop, start} = 3'b000;
    endtask

    // ctl is held during the cycle in which the synchronised edge is acted on
    task automatic slow_pulse(input logic [2:0] ctl, input bit lat);
        int t0;
        @(negedge clk_in);
        slow_clk = 1'b1;
        t0 = tick_cnt;
        @(negedge clk_in);
        @(negedge clk_in);
        {clear, stop, start} = ctl;
        if (lat) chk("latency_pre", tick_cnt - t0, 0);
        @(negedge clk_in);
        {clear, stop, start} = 3'b000;
        if (lat) chk("latency_edge3", tick_cnt - t0, 1);
        repeat (2) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clk_in);
    endtask

    task automatic edges(input int n);
        repeat (n) slow_pulse(3'b000, 1'b0);
    endtask

    task automatic check_time(input string nm, input logic [15:0] want);
        chk(nm, {min_tens, min_ones, sec_tens, sec_ones}, want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int per;
        cycles(3);
        check_time("reset_digits", 16'h0000);
        chk("reset_running", running, 0);
        chk("reset_tick", tick_out, 0);
        chk("reset_rollover", rollover, 0);
        @(negedge clk_in);
        rst = 1'b0;
        cycles(2);

        pulse(3'b001);
        t = tick_cnt;
        slow_pulse(3'b000, 1'b1);
        edges(2);
        check_time("three_edges", 16'h0003);
        chk("three_ticks", tick_cnt - t, 3);

        edges(56);
        check_time("sec_59", 16'h0059);
        edges(1);
        check_time("min_carry", 16'h0100);
        chk("no_roll_yet", roll_cnt, 0);

        edges(119);
        check_time("at_limit", 16'h0259);
        edges(1);
        check_time("wrapped", 16'h0000);
        chk("roll_once", roll_cnt, 1);
        chk("run_after_wrap", running, 1);

        edges(5);
        check_time("at_5", 16'h0005);
        slow_pulse(3'b010, 1'b0);
        check_time("stop_with_edge", 16'h0005);
        chk("paused", running, 0);
        edges(2);
        check_time("pause_discard", 16'h0005);
        pulse(3'b001);
        edges(1);
        check_time("resume", 16'h0006);
        chk("resumed", running, 1);

        edges(4);
        check_time("at_10", 16'h0010);
        t = tick_cnt;
        slow_pulse(3'b111, 1'b0);
        check_time("clear_all", 16'h0000);
        chk("clear_idle", running, 0);
        chk("clear_no_tick", tick_cnt - t, 0);

        @(negedge clk_in);
        slow_clk = 1'b1;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(10);
        t = tick_cnt;
        pulse(3'b001);
        cycles(10);
        check_time("held_high", 16'h0000);
        chk("held_high_ticks", tick_cnt - t, 0);
        slow_clk = 1'b0;
        cycles(5);
        edges(7);
        check_time("at_7", 16'h0007);
        @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        check_time("async_reset", 16'h0000);
        chk("async_running", running, 0);
        @(negedge clk_in);
        rst = 1'b0;

        per = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            if (per == 0) begin
                slow_clk = ~slow_clk;
                per = $urandom_range(1, 8);
            end else begin
                per--;
            end
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            clear = ($urandom_range(0, 127) == 0);
            rst   = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk_in);
        {clear, stop, start} = 3'b000;
        rst = 1'b0;
        slow_clk = 1'b0;
        cycles(10);
        check_time("random_final", to_bcd(secs));
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
